// File: rtl/fade_sequencer.sv
// PWM duty-cycle fade sequencer: ramps duty up to a latched peak, holds, ramps back down,
// optionally repeating, with every ramp step paced by a divided PWM-period tick.
module fade_sequencer #(
    parameter int unsigned STEP = 1
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Repeat,
    input  logic       PeriodTick,
    input  logic [7:0] Target,
    input  logic [7:0] StepDiv,
    input  logic [3:0] Hold,
    output logic [7:0] DUTYCONTROL,
    output logic       Busy,
    output logic       Done,
    output logic [1:0] State,
    output logic [7:0] Cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RISE = 2'b01,
        S_HOLD = 2'b10,
        S_FALL = 2'b11
    } state_t;

    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [7:0] STEP8 = 8'(STEP);

    state_t     r_state,    w_state_nx;
    logic [7:0] r_duty,     w_duty_nx;
    logic [7:0] r_tick,     w_tick_nx;
    logic [7:0] r_target,   w_target_nx;
    logic [7:0] r_div,      w_div_nx;
    logic [7:0] r_cycles,   w_cycles_nx;
    logic [3:0] r_hold_lim, w_hold_lim_nx;
    logic [3:0] r_hold_cnt, w_hold_cnt_nx;
    logic       r_done,     w_done_nx;
    logic       r_abort,    w_abort_nx;

    logic [7:0] w_div_eff;
    logic       w_step;
    logic [8:0] w_sum;

    // A latched divider of zero behaves exactly like a divider of one.
    assign w_div_eff = (r_div == 8'd0) ? 8'd1 : r_div;
    assign w_step    = PeriodTick && (({1'b0, r_tick} + 9'd1) == {1'b0, w_div_eff});
    assign w_sum     = {1'b0, r_duty} + STEP9;

    always_comb begin
        // NOTE: every next-value signal gets a default before the case so no latch is inferred.
        w_state_nx    = r_state;
        w_duty_nx     = r_duty;
        w_tick_nx     = r_tick;
        w_target_nx   = r_target;
        w_div_nx      = r_div;
        w_cycles_nx   = r_cycles;
        w_hold_lim_nx = r_hold_lim;
        w_hold_cnt_nx = r_hold_cnt;
        w_done_nx     = 1'b0;
        w_abort_nx    = r_abort;

        if (PeriodTick) begin
            w_tick_nx = w_step ? 8'd0 : r_tick + 8'd1;
        end

        unique case (r_state)
            S_IDLE: begin
                w_duty_nx = 8'd0;
                if (Start && !Stop) begin
                    w_tick_nx     = 8'd0;
                    w_target_nx   = Target;
                    w_div_nx      = StepDiv;
                    w_hold_lim_nx = Hold;
                    w_cycles_nx   = 8'd0;
                    w_abort_nx    = 1'b0;
                    if (Target == 8'd0) begin
                        w_done_nx = 1'b1;
                    end else begin
                        w_state_nx = S_RISE;
                    end
                end
            end
            S_RISE: begin
                if (w_step) begin
                    if (w_sum >= {1'b0, r_target}) begin
                        w_duty_nx     = r_target;
                        w_state_nx    = S_HOLD;
                        w_hold_cnt_nx = 4'd0;
                    end else begin
                        w_duty_nx = w_sum[7:0];
                    end
                end
                // An abort overrides a same-cycle arrival at the peak.
                if (Stop) begin
                    w_state_nx = S_FALL;
                    w_abort_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == r_hold_lim) begin
                    w_state_nx = S_FALL;
                end else if (w_step) begin
                    w_hold_cnt_nx = r_hold_cnt + 4'd1;
                end
                if (Stop) begin
                    w_state_nx = S_FALL;
                    w_abort_nx = 1'b1;
                end
            end
            S_FALL: begin
                if (w_step) begin
                    if (r_duty <= STEP8) begin
                        w_duty_nx   = 8'd0;
                        w_cycles_nx = r_cycles + 8'd1;
                        if (Repeat && !r_abort) begin
                            w_state_nx = S_RISE;
                        end else begin
                            w_state_nx = S_IDLE;
                            w_done_nx  = 1'b1;
                            w_abort_nx = 1'b0;
                        end
                    end else begin
                        w_duty_nx = r_duty - STEP8;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_duty     <= 8'd0;
            r_tick     <= 8'd0;
            r_target   <= 8'd0;
            r_div      <= 8'd0;
            r_cycles   <= 8'd0;
            r_hold_lim <= 4'd0;
            r_hold_cnt <= 4'd0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_duty     <= w_duty_nx;
            r_tick     <= w_tick_nx;
            r_target   <= w_target_nx;
            r_div      <= w_div_nx;
            r_cycles   <= w_cycles_nx;
            r_hold_lim <= w_hold_lim_nx;
            r_hold_cnt <= w_hold_cnt_nx;
            r_done     <= w_done_nx;
            r_abort    <= w_abort_nx;
        end
    end

    assign DUTYCONTROL = r_duty;
    assign Busy        = (r_state != S_IDLE);
    assign Done        = r_done;
    assign State       = r_state;
    assign Cycles      = r_cycles;

endmodule

// File: tb/tb_fade_sequencer.sv
// Bench for fade_sequencer: two instances (STEP=1 and STEP=100) share stimulus and are each
// compared every cycle against an arithmetic reference model, plus hand-computed fade traces.
module tb_fade_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, stop_i, rep_i, tick_i;
    logic [7:0] target_i, div_i;
    logic [3:0] hold_i;

    logic [7:0] duty_s1, cycles_s1, duty_s100, cycles_s100;
    logic       busy_s1, done_s1, busy_s100, done_s100;
    logic [1:0] state_s1, state_s100;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    fade_sequencer #(.STEP(1)) u_dut_s1 (
        .CLOCK_50(clk), .Resetn(rst_n), .Start(start_i), .Stop(stop_i), .Repeat(rep_i),
        .PeriodTick(tick_i), .Target(target_i), .StepDiv(div_i), .Hold(hold_i),
        .DUTYCONTROL(duty_s1), .Busy(busy_s1), .Done(done_s1), .State(state_s1), .Cycles(cycles_s1)
    );

    fade_sequencer #(.STEP(100)) u_dut_s100 (
        .CLOCK_50(clk), .Resetn(rst_n), .Start(start_i), .Stop(stop_i), .Repeat(rep_i),
        .PeriodTick(tick_i), .Target(target_i), .StepDiv(div_i), .Hold(hold_i),
        .DUTYCONTROL(duty_s100), .Busy(busy_s100), .Done(done_s100), .State(state_s100), .Cycles(cycles_s100)
    );

    // Reference model: phase 0 idle, 1 rising, 2 at peak, 3 falling.
    typedef struct {
        int phase;
        int duty;
        int ticks;
        int holds;
        int cycles;
        bit done;
        bit aborted;
        int tgt;
        int div;
        int hld;
    } mdl_t;

    mdl_t m1, m100;

    function automatic mdl_t mdl_reset();
        mdl_t z;
        z = '{default: 0};
        return z;
    endfunction

    function automatic mdl_t model_next(mdl_t m, int step, bit start, bit stop, bit rep, bit pt,
                                        int tgt, int div, int hld);
        mdl_t n;
        bit   ev;
        int   period;
        n      = m;
        n.done = 1'b0;
        period = (m.div == 0) ? 1 : m.div;
        ev     = pt && (m.ticks + 1 == period);
        if (pt) n.ticks = ev ? 0 : m.ticks + 1;
        case (m.phase)
            0: begin
                if (start && !stop) begin
                    n.ticks = 0; n.tgt = tgt; n.div = div; n.hld = hld;
                    n.cycles = 0; n.aborted = 1'b0;
                    if (tgt == 0) n.done = 1'b1;
                    else          n.phase = 1;
                end
            end
            1: begin
                if (ev) begin
                    if (m.duty + step >= m.tgt) begin
                        n.duty = m.tgt; n.phase = 2; n.holds = 0;
                    end else begin
                        n.duty = m.duty + step;
                    end
                end
                if (stop) begin n.phase = 3; n.aborted = 1'b1; end
            end
            2: begin
                if (m.holds == m.hld) n.phase = 3;
                else if (ev)          n.holds = m.holds + 1;
                if (stop) begin n.phase = 3; n.aborted = 1'b1; end
            end
            default: begin
                if (ev) begin
                    if (m.duty <= step) begin
                        n.duty   = 0;
                        n.cycles = (m.cycles + 1) % 256;
                        if (rep && !m.aborted) n.phase = 1;
                        else begin n.phase = 0; n.done = 1'b1; n.aborted = 1'b0; end
                    end else begin
                        n.duty = m.duty - step;
                    end
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1   <= mdl_reset();
            m100 <= mdl_reset();
        end else begin
            m1   <= model_next(m1,   1,   start_i, stop_i, rep_i, tick_i, int'(target_i), int'(div_i), int'(hold_i));
            m100 <= model_next(m100, 100, start_i, stop_i, rep_i, tick_i, int'(target_i), int'(div_i), int'(hold_i));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("s1_duty",     32'(duty_s1),     m1.duty);
            check("s1_state",    32'(state_s1),    m1.phase);
            check("s1_busy",     32'(busy_s1),     32'(m1.phase != 0));
            check("s1_done",     32'(done_s1),     32'(m1.done));
            check("s1_cycles",   32'(cycles_s1),   m1.cycles);
            check("s100_duty",   32'(duty_s100),   m100.duty);
            check("s100_state",  32'(state_s100),  m100.phase);
            check("s100_busy",   32'(busy_s100),   32'(m100.phase != 0));
            check("s100_done",   32'(done_s100),   32'(m100.done));
            check("s100_cycles", 32'(cycles_s100), m100.cycles);
        end
    end

    // One clock cycle of stimulus; inputs change 2 time units after the rising edge.
    task automatic cyc(input bit st, input bit sp, input bit rp, input bit pt);
        start_i = st; stop_i = sp; rep_i = rp; tick_i = pt;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        start_i = 1'b0; stop_i = 1'b0; rep_i = 1'b0; tick_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_basic_fade(input string tag);
        int exp_duty  [18] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 3, 3, 2, 2, 1, 1, 0};
        int exp_state [18] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 0};
        target_i = 8'd4; div_i = 8'd2; hold_i = 4'd1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check({tag, "_start_state"}, 32'(state_s1), 1);
        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("%s_duty_t%0d", tag, i + 1), 32'(duty_s1), exp_duty[i]);
            check($sformatf("%s_state_t%0d", tag, i + 1), 32'(state_s1), exp_state[i]);
            if (i == 9) check({tag, "_model_peak"}, m1.duty, 4);
        end
        check({tag, "_done"},   32'(done_s1),   1);
        check({tag, "_busy"},   32'(busy_s1),   0);
        check({tag, "_cycles"}, 32'(cycles_s1), 1);
        check({tag, "_model_cycles"}, m1.cycles, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, "_done_drop"}, 32'(done_s1), 0);
    endtask

    initial begin
        int mx;
        rst_n = 1'b0;
        start_i = 1'b0; stop_i = 1'b0; rep_i = 1'b0; tick_i = 1'b0;
        target_i = 8'd0; div_i = 8'd0; hold_i = 4'd0;
        #1;
        check("rst_duty",  32'(duty_s1),  0);
        check("rst_state", 32'(state_s1), 0);
        check("rst_busy",  32'(busy_s1),  0);
        check("rst_done",  32'(done_s1),  0);
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Basic rise / hold / fall with divided ticks.
        run_basic_fade("basic");

        // Large step saturates at the peak and falls without wrapping.
        do_reset();
        begin
            int exp_d [7] = '{100, 200, 250, 250, 150, 50, 0};
            int exp_s [7] = '{1, 1, 2, 3, 3, 3, 0};
            target_i = 8'd250; div_i = 8'd1; hold_i = 4'd0;
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 7; i++) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b1);
                check($sformatf("big_duty_t%0d", i + 1), 32'(duty_s100), exp_d[i]);
                check($sformatf("big_state_t%0d", i + 1), 32'(state_s100), exp_s[i]);
            end
            check("big_done", 32'(done_s100), 1);
        end

        // Stop during rise aborts to fall and finishes in idle even with Repeat high.
        do_reset();
        target_i = 8'd4; div_i = 8'd2; hold_i = 4'd1;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("stop_pre_duty",  32'(duty_s1),  2);
        check("stop_pre_state", 32'(state_s1), 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("stop_fall_state", 32'(state_s1), 3);
        check("stop_fall_duty",  32'(duty_s1),  2);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("stop_duty_1", 32'(duty_s1), 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("stop_duty_0", 32'(duty_s1),  0);
        check("stop_done",   32'(done_s1),  1);
        check("stop_idle",   32'(state_s1), 0);

        // Repeat keeps cycling, Cycles wraps after 256 ends, dropping Repeat finishes.
        do_reset();
        target_i = 8'd2; div_i = 8'd1; hold_i = 4'd0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 1280; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            if (i <= 10) check($sformatf("rep_no_done_t%0d", i), 32'(done_s1), 0);
            if (i == 3)  check("rep_peak", 32'(duty_s1), 2);
            if (i == 5)  check("rep_cycles_1", 32'(cycles_s1), 1);
            if (i == 6)  check("rep_restart", 32'(duty_s1), 1);
            if (i == 10) check("rep_cycles_2", 32'(cycles_s1), 2);
        end
        check("rep_wrap", 32'(cycles_s1), 0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("rep_end_done",   32'(done_s1),   1);
        check("rep_end_state",  32'(state_s1),  0);
        check("rep_end_cycles", 32'(cycles_s1), 1);

        // Start while busy is ignored; Start with Stop in idle is ignored; zero peak finishes at once.
        do_reset();
        target_i = 8'd4; div_i = 8'd1; hold_i = 4'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        target_i = 8'd9;
        mx = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (int'(duty_s1) > mx) mx = int'(duty_s1);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("busy_start_peak",   mx, 4);
        check("busy_start_idle",   32'(state_s1),  0);
        check("busy_start_cycles", 32'(cycles_s1), 1);
        target_i = 8'd5;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("startstop_state", 32'(state_s1), 0);
        check("startstop_busy",  32'(busy_s1),  0);
        target_i = 8'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("zero_done",   32'(done_s1),   1);
        check("zero_state",  32'(state_s1),  0);
        check("zero_cycles", 32'(cycles_s1), 0);
        check("zero_duty",   32'(duty_s1),   0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("zero_done_drop", 32'(done_s1), 0);

        // Asynchronous reset in the middle of the peak, then a clean rerun.
        do_reset();
        target_i = 8'd4; div_i = 8'd2; hold_i = 4'd1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("mid_hold_state", 32'(state_s1), 2);
        check("mid_hold_duty",  32'(duty_s1),  4);
        tick_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_duty",  32'(duty_s1),  0);
        check("async_state", 32'(state_s1), 0);
        check("async_busy",  32'(busy_s1),  0);
        check("async_done",  32'(done_s1),  0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_done", 32'(done_s1), 0);
        run_basic_fade("rerun");

        // Randomized traffic checked every cycle against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 15) == 0) begin
                target_i = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
                div_i    = 8'($urandom_range(0, 3));
                hold_i   = 4'($urandom_range(0, 3));
            end
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fade_sequencer.md
FADE_SEQUENCER -- requirements
Module: fade_sequencer

Interface
REQ-001 Parameter STEP, default 1: duty increment/decrement per step event (1..255).
REQ-002 Port CLOCK_50  input  1: system clock; all state changes on rising edge.
REQ-003 Port Resetn  input  1: asynchronous, active-low reset.
REQ-004 Port Start  input  1: one-cycle request to begin a fade cycle.
REQ-005 Port Stop  input  1: level request to abort to fall-off.
REQ-006 Port Repeat  input  1: when high at end of fall, restart rise instead of finishing.
REQ-007 Port PeriodTick  input  1: one-cycle pulse per PWM8 period (counter wrap).
REQ-008 Port Target  input  8: peak duty, latched at Start.
REQ-009 Port StepDiv  input  8: PWM periods per step event, latched at Start; 0 treated as 1.
REQ-010 Port Hold  input  4: step events spent at peak, latched at Start.
REQ-011 Port DUTYCONTROL  output  8: duty value driven to PWM8.
REQ-012 Port Busy  output  1: high in any state other than IDLE.
REQ-013 Port Done  output  1: one-cycle pulse on completion.
REQ-014 Port State  output  2: IDLE=00, RISE=01, HOLD=10, FALL=11.
REQ-015 Port Cycles  output  8: count of completed rise/fall cycles since Start, wraps 255->0.

Function
REQ-016 Step event: internal tick counter increments on PeriodTick; when count+1 equals latched StepDiv, assert step event that cycle and clear counter; counter cleared on accepted Start.
REQ-017 IDLE: DUTYCONTROL=0; Start with Stop low -> latch Target/StepDiv/Hold, clear Cycles, enter RISE next cycle.
REQ-018 IDLE with Start and Stop both high: Start ignored, remain IDLE.
REQ-019 Start with latched Target=0: enter IDLE next cycle with Done pulse, Cycles=0, DUTYCONTROL stays 0.
REQ-020 RISE: on step event, 9-bit sum DUTYCONTROL+STEP; if sum >= Target, DUTYCONTROL<=Target and enter HOLD; else DUTYCONTROL<=sum.
REQ-021 HOLD: hold counter cleared on entry, increments per step event; when hold counter equals latched Hold, enter FALL next cycle (Hold=0 -> one cycle in HOLD).
REQ-022 FALL: on step event, if DUTYCONTROL <= STEP then DUTYCONTROL<=0 and cycle ends, else DUTYCONTROL<=DUTYCONTROL-STEP.
REQ-023 Cycle end: Cycles increments; Repeat high -> RISE, no Done; Repeat low -> IDLE, Done high for exactly that one following cycle, Busy low.
REQ-024 Stop high in RISE or HOLD: enter FALL next cycle from current DUTYCONTROL; Stop in FALL or IDLE has no effect; Stop forces cycle end to IDLE regardless of Repeat.
REQ-025 Start while Busy ignored; latched values unchanged.
REQ-026 DUTYCONTROL changes only on step events or reset; never exceeds latched Target; never wraps.
REQ-027 PeriodTick and state transition in same cycle: step evaluated in current state before transition.

Reset
REQ-028 Resetn low: immediately State=IDLE, DUTYCONTROL=0, Busy=0, Done=0, Cycles=0, tick and hold counters 0, latched registers 0.
REQ-029 Reset mid-fade: output goes to 0 without ramp; Done not asserted; first Start after release behaves as from power-up.

Verification
REQ-030 STEP=1, Target=4, StepDiv=2, Hold=1, Repeat=0, Start -> DUTYCONTROL 1,2,3,4 on ticks 2,4,6,8; HOLD until tick 10; 3,2,1,0 on ticks 12..18; Done one cycle after tick 18; Cycles=1.
REQ-031 STEP=100, Target=250, StepDiv=1, Hold=0 -> RISE 100,200,250 (saturated), FALL 150,50,0; no wrap.
REQ-032 Target=4, StepDiv=2, Stop asserted when DUTYCONTROL=2 in RISE -> FALL next cycle, 1 then 0, Done pulse, State=IDLE.
REQ-033 Repeat=1, Target=2, StepDiv=1, Hold=0 -> continuous 1,2,1,0,1,2...; Cycles increments each return to 0; Done never asserted; drop Repeat -> next end goes IDLE with Done.
REQ-034 Start while Busy with new Target=9 -> ignored, peak remains original Target; Start+Stop in IDLE -> stays IDLE.
REQ-035 Resetn pulsed low mid-HOLD with DUTYCONTROL=4 -> all outputs 0 asynchronously, no Done; subsequent Start runs REQ-030 sequence.
